// File: rtl/pixel_capture_pkg.sv
// pixel_capture_pkg
//   Shared definitions for the pixel capture unit: input-format encodings,
//   FSM state encoding, default geometry and a saturating counter helper.
//   No ports (package).
package pixel_capture_pkg;

  localparam int DEF_WIDTH  = 176;
  localparam int DEF_HEIGHT = 144;
  localparam int DEF_ADDR_W = 15;
  localparam int DEF_CNT_W  = 8;

  // Width of the x/y pixel/line counters; wide enough that a runaway line
  // still compares unequal to WIDTH/HEIGHT instead of wrapping back onto it.
  localparam int XY_W = 16;

  typedef enum logic [1:0] {
    MODE_RGB565 = 2'd0,
    MODE_RGB555 = 2'd1,
    MODE_RGB444 = 2'd2,
    MODE_YUV    = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_VS   = 3'd1,
    ST_WAIT_LINE = 3'd2,
    ST_LINE      = 3'd3,
    ST_END       = 3'd4
  } state_e;

  // Increment that sticks at all-ones.
  function automatic logic [XY_W-1:0] sat_inc(input logic [XY_W-1:0] v);
    logic [XY_W-1:0] r;
    if (v == {XY_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(XY_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/pixel_capture_unit_pixel_format_converter.sv
// pixel_format_converter
//   Combinational conversion of one two-byte camera pixel to RGB332.
//   Ports:
//     b1     in  8  first byte of the pixel
//     b2     in  8  second byte of the pixel (unused in luma-only mode)
//     mode   in  2  input format (mode_e encoding)
//     rgb332 out 8  converted pixel {R[2:0], G[2:0], B[1:0]}
module pixel_format_converter
  import pixel_capture_pkg::*;
(
  input  logic [7:0] b1,
  input  logic [7:0] b2,
  input  logic [1:0] mode,
  output logic [7:0] rgb332
);

  // No format keeps information in the two lowest bits of the second byte.
  logic unused_b2_lsbs;
  assign unused_b2_lsbs = ^b2[1:0];

  // Keep the top bits of each colour component for the selected format.
  always_comb begin
    rgb332 = 8'h00;
    case (mode_e'(mode))
      MODE_RGB565: rgb332 = {b1[7:5], b1[2:0], b2[4:3]};
      MODE_RGB555: rgb332 = {b1[6:4], b1[1:0], b2[7], b2[4:3]};
      MODE_RGB444: rgb332 = {b1[3:1], b2[7:5], b2[3:2]};
      MODE_YUV:    rgb332 = {b1[7:5], b1[7:5], b1[7:6]};
      default:     rgb332 = 8'h00;
    endcase
  end

endmodule

// File: rtl/pixel_capture_unit.sv
// pixel_capture_unit
//   Captures a VSYNC/HREF framed 8-bit camera stream (two bytes per pixel),
//   converts pixels to RGB332 and writes them linearly into a frame buffer.
//   Ports:
//     CLK, RESET_N           pixel clock, synchronous active-low reset
//     VSYNC, HREF, DATA      camera frame sync, line valid, byte bus
//     MODE                   input format, sampled at frame start
//     CONT, ARM              continuous capture / snapshot request pulse
//     W_ADDR, W_DATA, W_EN   frame-buffer write port (registered)
//     BUSY                   frame capture in progress
//     FRAME_DONE             one-cycle pulse per captured frame
//     FRAME_ERR              line/pixel count mismatch of the last frame
//     FRAME_COUNT            wrapping completed-frame counter
module pixel_capture_unit
  import pixel_capture_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [7:0]        DATA,
  input  logic [1:0]        MODE,
  input  logic              CONT,
  input  logic              ARM,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              W_EN,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              FRAME_ERR,
  output logic [CNT_W-1:0]  FRAME_COUNT
);

  localparam logic [XY_W-1:0]   X_LIM    = XY_W'(WIDTH);
  localparam logic [XY_W-1:0]   Y_LIM    = XY_W'(HEIGHT);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);

  state_e            state_q, state_d;
  logic              vsync_q, href_q;
  logic              arm_q, arm_d;
  logic              phase_q, phase_d;
  logic [7:0]        b1_q, b1_d;
  logic [1:0]        mode_q, mode_d;
  logic [XY_W-1:0]   x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [7:0]        w_data_q, w_data_d;
  logic              w_en_q, w_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        pix_s;
  logic              vs_fall_s, vs_rise_s, href_rise_s, href_fall_s;

  assign vs_fall_s   = vsync_q & ~VSYNC;
  assign vs_rise_s   = VSYNC & ~vsync_q;
  assign href_rise_s = HREF & ~href_q;
  assign href_fall_s = href_q & ~HREF;

  pixel_format_converter u_conv (
    .b1     (b1_q),
    .b2     (DATA),
    .mode   (mode_q),
    .rgb332 (pix_s)
  );

  // Next-state, counters and write-port computation.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    b1_d       = b1_q;
    mode_d     = mode_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    w_en_d     = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    count_d    = count_q;
    // The arm flag is consumed at frame start rather than at END, so an ARM
    // received while a frame is being captured survives into the next one.
    arm_d      = arm_q | (ARM & ~CONT);

    case (state_q)
      ST_IDLE: begin
        if (CONT || arm_q) begin
          state_d = ST_WAIT_VS;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_VS: begin
        if (vs_fall_s && (CONT || arm_q)) begin
          mode_d     = MODE;
          err_d      = 1'b0;
          x_d        = '0;
          y_d        = '0;
          row_base_d = '0;
          busy_d     = 1'b1;
          arm_d      = ARM & ~CONT;
          state_d    = ST_WAIT_LINE;
        end else if (!CONT && !arm_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_VS;
        end
      end

      ST_WAIT_LINE: begin
        if (vs_rise_s) begin
          state_d = ST_END;
        end else if (href_rise_s) begin
          // The byte present on the rising edge of HREF is already the first
          // byte of pixel 0, so it is stored here and LINE starts at phase 1.
          x_d     = '0;
          b1_d    = DATA;
          phase_d = 1'b1;
          state_d = ST_LINE;
        end else begin
          state_d = ST_WAIT_LINE;
        end
      end

      ST_LINE: begin
        if (vs_rise_s) begin
          err_d   = 1'b1;
          phase_d = 1'b0;
          state_d = ST_END;
        end else if (href_fall_s) begin
          if (x_q != X_LIM) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          y_d        = sat_inc(y_q);
          row_base_d = row_base_q + ROW_STEP;
          phase_d    = 1'b0;
          state_d    = ST_WAIT_LINE;
        end else if (!phase_q) begin
          b1_d    = DATA;
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          x_d     = sat_inc(x_q);
          if ((x_q < X_LIM) && (y_q < Y_LIM)) begin
            w_en_d   = 1'b1;
            w_addr_d = row_base_q + ADDR_W'(x_q);
            w_data_d = pix_s;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_END: begin
        done_d  = 1'b1;
        count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (y_q != Y_LIM) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      arm_q      <= 1'b0;
      phase_q    <= 1'b0;
      b1_q       <= 8'h00;
      mode_q     <= 2'd0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      w_addr_q   <= '0;
      w_data_q   <= 8'h00;
      w_en_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= VSYNC;
      href_q     <= HREF;
      arm_q      <= arm_d;
      phase_q    <= phase_d;
      b1_q       <= b1_d;
      mode_q     <= mode_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      w_en_q     <= w_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  assign W_ADDR      = w_addr_q;
  assign W_DATA      = w_data_q;
  assign W_EN        = w_en_q;
  assign BUSY        = busy_q;
  assign FRAME_DONE  = done_q;
  assign FRAME_ERR   = err_q;
  assign FRAME_COUNT = count_q;

endmodule

// File: tb/tb_pixel_capture_unit.sv
// tb_pixel_capture_unit
//   Randomised bench for pixel_capture_unit (WIDTH=3, HEIGHT=2) with a
//   frame-level reference model, plus a standalone converter check.
module tb_pixel_capture_unit;

  localparam int W  = 3;
  localparam int H  = 2;
  localparam int AW = 15;
  localparam int CW = 8;

  logic          CLK = 1'b0;
  logic          RESET_N, VSYNC, HREF, CONT, ARM;
  logic [7:0]    DATA;
  logic [1:0]    MODE;
  logic [AW-1:0] W_ADDR;
  logic [7:0]    W_DATA;
  logic          W_EN, BUSY, FRAME_DONE, FRAME_ERR;
  logic [CW-1:0] FRAME_COUNT;

  logic [7:0] cv_b1, cv_b2, cv_out;
  logic [1:0] cv_mode;

  always #5 CLK = ~CLK;

  pixel_capture_unit #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .VSYNC(VSYNC), .HREF(HREF), .DATA(DATA),
    .MODE(MODE), .CONT(CONT), .ARM(ARM), .W_ADDR(W_ADDR), .W_DATA(W_DATA),
    .W_EN(W_EN), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR),
    .FRAME_COUNT(FRAME_COUNT)
  );

  pixel_format_converter u_cv (
    .b1(cv_b1), .b2(cv_b2), .mode(cv_mode), .rgb332(cv_out)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int obs_addr[$];
  int obs_data[$];
  int done_cnt = 0;
  int bpl[8];
  int exp_count = 0;
  bit armed = 1'b0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference conversion: split the input into colour components, then keep
  // the most significant 3/3/2 bits of R/G/B.
  function automatic logic [7:0] ref_rgb332(input logic [7:0] b1, input logic [7:0] b2,
                                            input logic [1:0] m);
    int i1, i2, r, g, b, o;
    i1 = int'(b1);
    i2 = int'(b2);
    case (m)
      2'd0: begin r = i1 >> 3; g = ((i1 & 7) << 3) | (i2 >> 5); b = i2 & 31;
                  o = ((r >> 2) << 5) | ((g >> 3) << 2) | (b >> 3); end
      2'd1: begin r = (i1 >> 2) & 31; g = ((i1 & 3) << 3) | (i2 >> 5); b = i2 & 31;
                  o = ((r >> 2) << 5) | ((g >> 2) << 2) | (b >> 3); end
      2'd2: begin r = i1 & 15; g = i2 >> 4; b = i2 & 15;
                  o = ((r >> 1) << 5) | ((g >> 1) << 2) | (b >> 2); end
      default: begin o = ((i1 >> 5) << 5) | ((i1 >> 5) << 2) | (i1 >> 6); end
    endcase
    return 8'(o);
  endfunction

  // Collect writes and frame-done pulses away from the active edge.
  always @(negedge CLK) begin
    if (W_EN) begin
      obs_addr.push_back(int'(W_ADDR));
      obs_data.push_back(int'(W_DATA));
    end
    if (FRAME_DONE) done_cnt++;
  end

  // Drive one VSYNC-framed frame with bpl[l] bytes on line l and check the
  // resulting writes, done pulse, frame counter and error flag.
  task automatic send_frame(input int nlines, input bit fixed, input logic [7:0] fb1,
                            input logic [7:0] fb2, input int toggle_to, input string tag);
    bit         cap, eerr;
    logic [1:0] fmode;
    logic [7:0] b1;
    int         ea[$];
    int         ed[$];
    int         p;
    obs_addr.delete();
    obs_data.delete();
    done_cnt = 0;
    b1 = 8'h00;
    cap = CONT || armed;
    armed = 1'b0;
    fmode = MODE;
    eerr = (nlines != H);
    step(); VSYNC = 1'b0;
    step(); step();
    for (int l = 0; l < nlines; l++) begin
      HREF = 1'b1;
      for (int k = 0; k < bpl[l]; k++) begin
        if (fixed) DATA = (k % 2 == 0) ? fb1 : fb2;
        else DATA = 8'($urandom_range(0, 255));
        if (k % 2 == 0) begin
          b1 = DATA;
        end else begin
          p = k / 2;
          if (p < W && l < H) begin
            ea.push_back(l * W + p);
            ed.push_back(int'(ref_rgb332(b1, DATA, fmode)));
          end
        end
        step();
      end
      HREF = 1'b0;
      DATA = 8'h00;
      if (bpl[l] / 2 != W) eerr = 1'b1;
      step(); step(); step();
      if (toggle_to >= 0 && l == 0) MODE = 2'(toggle_to);
    end
    VSYNC = 1'b1;
    repeat (6) step();
    if (cap) exp_count++;
    else begin
      ea.delete();
      ed.delete();
    end
    check_val({tag, " nwrites"}, obs_addr.size(), ea.size());
    for (int i = 0; i < ea.size() && i < obs_addr.size(); i++) begin
      check_val($sformatf("%s addr[%0d]", tag, i), obs_addr[i], ea[i]);
      check_val($sformatf("%s data[%0d]", tag, i), obs_data[i], ed[i]);
    end
    check_val({tag, " done"}, done_cnt, cap ? 1 : 0);
    check_val({tag, " count"}, FRAME_COUNT, exp_count % 256);
    check_val({tag, " busy"}, BUSY, 0);
    if (cap) check_val({tag, " err"}, FRAME_ERR, eerr);
  endtask

  task automatic set_bpl(input int n);
    for (int i = 0; i < 8; i++) bpl[i] = n;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, " w_en"}, W_EN, 0);
    check_val({tag, " w_addr"}, W_ADDR, 0);
    check_val({tag, " w_data"}, W_DATA, 0);
    check_val({tag, " busy"}, BUSY, 0);
    check_val({tag, " done"}, FRAME_DONE, 0);
    check_val({tag, " err"}, FRAME_ERR, 0);
    check_val({tag, " count"}, FRAME_COUNT, 0);
  endtask

  initial begin
    RESET_N = 1'b0; VSYNC = 1'b1; HREF = 1'b0; DATA = 8'h00;
    MODE = 2'd0; CONT = 1'b1; ARM = 1'b0;
    cv_b1 = 8'h00; cv_b2 = 8'h00; cv_mode = 2'd0;
    step(); step();
    check_all_zero("reset");
    RESET_N = 1'b1;
    repeat (3) step();

    // Standalone converter: directed vectors then random ones.
    cv_mode = 2'd2; cv_b1 = 8'h0F; cv_b2 = 8'hF0; #1 check_val("conv rgb444", cv_out, 8'hFC);
    cv_mode = 2'd3; cv_b1 = 8'h80; cv_b2 = 8'h00; #1 check_val("conv yuv", cv_out, 8'h92);
    cv_mode = 2'd1; cv_b1 = 8'h7C; cv_b2 = 8'h1F; #1 check_val("conv rgb555", cv_out, 8'hE3);
    cv_mode = 2'd0; cv_b1 = 8'hF8; cv_b2 = 8'h00; #1 check_val("conv rgb565", cv_out, 8'hE0);
    for (int i = 0; i < 40; i++) begin
      cv_mode = 2'($urandom_range(0, 3));
      cv_b1 = 8'($urandom_range(0, 255));
      cv_b2 = 8'($urandom_range(0, 255));
      #1 check_val("conv rand", cv_out, ref_rgb332(cv_b1, cv_b2, cv_mode));
    end

    // Basic continuous frame, then directed formats, then random frames.
    set_bpl(2 * W);
    send_frame(H, 1'b1, 8'hF8, 8'h00, -1, "t1 rgb565");
    MODE = 2'd2; send_frame(H, 1'b1, 8'h0F, 8'hF0, -1, "t2 rgb444");
    MODE = 2'd3; send_frame(H, 1'b1, 8'h80, 8'h00, -1, "t2 yuv");
    MODE = 2'd1; send_frame(H, 1'b1, 8'h7C, 8'h1F, -1, "t2 rgb555");
    for (int i = 0; i < 4; i++) begin
      MODE = 2'($urandom_range(0, 3));
      send_frame(H, 1'b0, 8'h00, 8'h00, -1, "rand frame");
    end

    // Boundaries: overlong line, short frame, odd byte count.
    bpl[0] = 10;
    send_frame(H, 1'b0, 8'h00, 8'h00, -1, "t3 long line");
    set_bpl(2 * W);
    send_frame(1, 1'b0, 8'h00, 8'h00, -1, "t3 short frame");
    set_bpl(2 * W + 1);
    send_frame(H, 1'b0, 8'h00, 8'h00, -1, "t3 odd bytes");
    set_bpl(2 * W);

    // Snapshot: ARM ignored under CONT, no capture unarmed, one frame per ARM.
    ARM = 1'b1; step(); ARM = 1'b0; step();
    CONT = 1'b0; repeat (3) step();
    send_frame(H, 1'b0, 8'h00, 8'h00, -1, "t4 unarmed a");
    send_frame(H, 1'b0, 8'h00, 8'h00, -1, "t4 unarmed b");
    ARM = 1'b1; armed = 1'b1; step(); ARM = 1'b0; repeat (3) step();
    send_frame(H, 1'b0, 8'h00, 8'h00, -1, "t4 armed");
    send_frame(H, 1'b0, 8'h00, 8'h00, -1, "t4 after armed");
    CONT = 1'b1; repeat (3) step();

    // Reset in the middle of a line, then a normal frame from address 0.
    step(); VSYNC = 1'b0; step(); step();
    HREF = 1'b1;
    for (int k = 0; k < 3; k++) begin DATA = 8'($urandom_range(0, 255)); step(); end
    RESET_N = 1'b0; DATA = 8'h55; step();
    check_all_zero("t5 after reset");
    RESET_N = 1'b1;
    exp_count = 0; armed = 1'b0;
    obs_addr.delete(); obs_data.delete(); done_cnt = 0;
    for (int k = 0; k < 3; k++) begin DATA = 8'($urandom_range(0, 255)); step(); end
    HREF = 1'b0; step(); step(); step();
    VSYNC = 1'b1; repeat (6) step();
    check_val("t5 aborted writes", obs_addr.size(), 0);
    check_val("t5 aborted done", done_cnt, 0);
    send_frame(H, 1'b0, 8'h00, 8'h00, -1, "t5 recovered");

    // MODE change mid-frame only applies from the next frame.
    MODE = 2'd0;
    send_frame(H, 1'b0, 8'h00, 8'h00, 3, "t6 toggled frame");
    send_frame(H, 1'b0, 8'h00, 8'h00, -1, "t6 next frame");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
